// File: rtl/mem_controller.sv
// Byte-serial master of the unified RAM/IO port: serves LSB loads/stores and instruction
// fetch, reassembling little-endian bytes and extending load data.
module mem_controller #(
  parameter int unsigned LSB_ID_W = 4,
  parameter logic [1:0]  IO_MASK  = 2'b11
) (
  input  logic                clk,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush,
  input  logic                lsb2mem_load_en,
  input  logic                lsb2mem_store_en,
  input  logic [31:0]         lsb2mem_addr,
  input  logic [2:0]          lsb2mem_type,
  input  logic [31:0]         lsb2mem_val,
  input  logic [LSB_ID_W-1:0] lsb2mem_load_id,
  output logic                mem_busy,
  output logic                mem2lsb_load_en,
  output logic [LSB_ID_W-1:0] mem2lsb_load_id,
  output logic [31:0]         mem2lsb_load_val,
  input  logic                if_req_en,
  input  logic [31:0]         if_addr,
  output logic                mem2if_en,
  output logic [31:0]         mem2if_inst,
  input  logic [7:0]          mem_din,
  output logic [7:0]          mem_dout,
  output logic [31:0]         mem_a,
  output logic                mem_wr,
  input  logic                io_buffer_full
);

  typedef enum logic [1:0] {StIdle, StLoad, StStore, StFetch} state_e;

  function automatic logic [2:0] f_nbytes(input logic [2:0] t);
    case (t[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  state_e                r_state, w_state_d;
  logic [2:0]            r_cnt, w_cnt_d;
  logic [31:0]           r_addr, w_addr_d;
  logic [2:0]            r_type, w_type_d;
  logic [31:0]           r_val, w_val_d;
  logic [LSB_ID_W-1:0]   r_id, w_id_d;
  logic [31:0]           r_buf, w_buf_d;
  logic                  r_sk_valid, w_sk_valid_d;
  logic                  r_sk_store, w_sk_store_d;
  logic [31:0]           r_sk_addr, w_sk_addr_d;
  logic [2:0]            r_sk_type, w_sk_type_d;
  logic [31:0]           r_sk_val, w_sk_val_d;
  logic [LSB_ID_W-1:0]   r_sk_id, w_sk_id_d;
  logic                  r_load_en, w_load_en_d;
  logic [LSB_ID_W-1:0]   r_load_id, w_load_id_d;
  logic [31:0]           r_load_val, w_load_val_d;
  logic                  r_if_en, w_if_en_d;
  logic [31:0]           r_if_inst, w_if_inst_d;
  logic                  r_busy, w_busy_d;

  logic                  w_idle, w_lsb_new, w_acc, w_acc_store;
  logic                  w_take_skid, w_take_store, w_take_load, w_take_fetch;
  logic [31:0]           w_acc_addr, w_acc_val;
  logic [2:0]            w_acc_type, w_n;
  logic [LSB_ID_W-1:0]   w_acc_id;
  logic [31:0]           w_mem_a, w_bytes, w_ext;
  logic [7:0]            w_dout;
  logic                  w_wr_req, w_stall;
  logic [1:0]            w_bidx;

  // A flush drops a skid load but never a skid store, which is already committed.
  assign w_idle       = (r_state == StIdle);
  assign w_lsb_new    = lsb2mem_store_en | (lsb2mem_load_en & ~flush);
  assign w_take_skid  = w_idle & r_sk_valid & (r_sk_store | ~flush);
  assign w_take_store = w_idle & ~w_take_skid & lsb2mem_store_en;
  assign w_take_load  = w_idle & ~w_take_skid & ~lsb2mem_store_en & lsb2mem_load_en & ~flush;
  assign w_take_fetch = w_idle & ~r_sk_valid & ~lsb2mem_store_en & ~lsb2mem_load_en &
                        if_req_en & ~flush;
  assign w_acc        = w_take_skid | w_take_store | w_take_load | w_take_fetch;
  assign w_acc_store  = w_take_skid ? r_sk_store : w_take_store;
  assign w_acc_addr   = w_take_skid ? r_sk_addr : (w_take_fetch ? if_addr : lsb2mem_addr);
  assign w_acc_type   = w_take_skid ? r_sk_type : (w_take_fetch ? 3'b010 : lsb2mem_type);
  assign w_acc_val    = w_take_skid ? r_sk_val : lsb2mem_val;
  assign w_acc_id     = w_take_skid ? r_sk_id : lsb2mem_load_id;
  assign w_n          = f_nbytes(r_type);

  // Port drive: combinational so the first byte address appears in the accept cycle.
  always_comb begin
    w_mem_a  = '0;
    w_dout   = '0;
    w_wr_req = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_acc) begin
          w_mem_a = w_acc_addr;
          if (w_acc_store) begin
            w_wr_req = 1'b1;
            w_dout   = w_acc_val[7:0];
          end
        end
      end
      StStore: begin
        w_mem_a  = r_addr + 32'(r_cnt);
        w_dout   = r_val[{r_cnt[1:0], 3'b000} +: 8];
        w_wr_req = 1'b1;
      end
      StLoad, StFetch: begin
        if (r_cnt < w_n) w_mem_a = r_addr + 32'(r_cnt);
      end
      default: w_mem_a = '0;
    endcase
  end

  assign w_stall  = (w_mem_a[17:16] == IO_MASK) & io_buffer_full;
  assign mem_a    = rst_in ? '0 : w_mem_a;
  assign mem_dout = rst_in ? '0 : w_dout;
  assign mem_wr   = ~rst_in & rdy_in & w_wr_req & ~w_stall;

  // Byte cnt-1 arrives on mem_din during cycle cnt of a read.
  assign w_bidx = 2'(r_cnt - 3'd1);
  always_comb begin
    w_bytes = r_buf;
    w_bytes[{w_bidx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    case (r_type)
      3'b000:  w_ext = {{24{w_bytes[7]}}, w_bytes[7:0]};
      3'b001:  w_ext = {{16{w_bytes[15]}}, w_bytes[15:0]};
      3'b100:  w_ext = {24'd0, w_bytes[7:0]};
      3'b101:  w_ext = {16'd0, w_bytes[15:0]};
      default: w_ext = w_bytes;
    endcase
  end

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_addr_d     = r_addr;
    w_type_d     = r_type;
    w_val_d      = r_val;
    w_id_d       = r_id;
    w_buf_d      = r_buf;
    w_sk_valid_d = r_sk_valid;
    w_sk_store_d = r_sk_store;
    w_sk_addr_d  = r_sk_addr;
    w_sk_type_d  = r_sk_type;
    w_sk_val_d   = r_sk_val;
    w_sk_id_d    = r_sk_id;
    w_load_en_d  = 1'b0;
    w_load_id_d  = r_load_id;
    w_load_val_d = r_load_val;
    w_if_en_d    = 1'b0;
    w_if_inst_d  = r_if_inst;

    if (flush && !r_sk_store) w_sk_valid_d = 1'b0;
    if (w_take_skid) w_sk_valid_d = 1'b0;
    if (w_lsb_new && (!w_idle || w_take_skid)) begin
      w_sk_valid_d = 1'b1;
      w_sk_store_d = lsb2mem_store_en;
      w_sk_addr_d  = lsb2mem_addr;
      w_sk_type_d  = lsb2mem_type;
      w_sk_val_d   = lsb2mem_val;
      w_sk_id_d    = lsb2mem_load_id;
    end

    case (r_state)
      StIdle: begin
        if (w_acc) begin
          w_addr_d = w_acc_addr;
          w_type_d = w_acc_type;
          w_val_d  = w_acc_val;
          w_id_d   = w_acc_id;
          w_buf_d  = '0;
          if (w_acc_store) begin
            if (w_stall) begin
              w_state_d = StStore;
              w_cnt_d   = 3'd0;
            end else if (f_nbytes(w_acc_type) != 3'd1) begin
              w_state_d = StStore;
              w_cnt_d   = 3'd1;
            end
          end else begin
            w_state_d = w_take_fetch ? StFetch : StLoad;
            w_cnt_d   = 3'd1;
          end
        end
      end
      StStore: begin
        if (!w_stall) begin
          if (r_cnt == w_n - 3'd1) w_state_d = StIdle;
          else                     w_cnt_d   = r_cnt + 3'd1;
        end
      end
      StLoad, StFetch: begin
        if (flush) begin
          w_state_d = StIdle;
        end else begin
          w_buf_d = w_bytes;
          if (r_cnt == w_n) begin
            w_state_d = StIdle;
            if (r_state == StFetch) begin
              w_if_en_d   = 1'b1;
              w_if_inst_d = w_bytes;
            end else begin
              w_load_en_d  = 1'b1;
              w_load_id_d  = r_id;
              w_load_val_d = w_ext;
            end
          end else begin
            w_cnt_d = r_cnt + 3'd1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase

    w_busy_d = (w_state_d != StIdle) | w_sk_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_type     <= '0;
      r_val      <= '0;
      r_id       <= '0;
      r_buf      <= '0;
      r_sk_valid <= 1'b0;
      r_sk_store <= 1'b0;
      r_sk_addr  <= '0;
      r_sk_type  <= '0;
      r_sk_val   <= '0;
      r_sk_id    <= '0;
      r_load_en  <= 1'b0;
      r_load_id  <= '0;
      r_load_val <= '0;
      r_if_en    <= 1'b0;
      r_if_inst  <= '0;
      r_busy     <= 1'b0;
    end else if (rdy_in) begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_addr     <= w_addr_d;
      r_type     <= w_type_d;
      r_val      <= w_val_d;
      r_id       <= w_id_d;
      r_buf      <= w_buf_d;
      r_sk_valid <= w_sk_valid_d;
      r_sk_store <= w_sk_store_d;
      r_sk_addr  <= w_sk_addr_d;
      r_sk_type  <= w_sk_type_d;
      r_sk_val   <= w_sk_val_d;
      r_sk_id    <= w_sk_id_d;
      r_load_en  <= w_load_en_d;
      r_load_id  <= w_load_id_d;
      r_load_val <= w_load_val_d;
      r_if_en    <= w_if_en_d;
      r_if_inst  <= w_if_inst_d;
      r_busy     <= w_busy_d;
    end
  end

  assign mem_busy         = r_busy;
  assign mem2lsb_load_en  = r_load_en;
  assign mem2lsb_load_id  = r_load_id;
  assign mem2lsb_load_val = r_load_val;
  assign mem2if_en        = r_if_en;
  assign mem2if_inst      = r_if_inst;

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: byte-addressed RAM model on the port, reference
// model computes load/fetch results and write sequences; a monitor checks DUT outputs.
module tb_mem_controller;
  localparam int IDW = 4;

  logic           clk = 1'b0;
  logic           rst_in, rdy_in, flush;
  logic           lsb2mem_load_en, lsb2mem_store_en;
  logic [31:0]    lsb2mem_addr, lsb2mem_val;
  logic [2:0]     lsb2mem_type;
  logic [IDW-1:0] lsb2mem_load_id;
  logic           mem_busy, mem2lsb_load_en, mem2if_en;
  logic [IDW-1:0] mem2lsb_load_id;
  logic [31:0]    mem2lsb_load_val, mem2if_inst;
  logic           if_req_en;
  logic [31:0]    if_addr;
  logic [7:0]     mem_din, mem_dout;
  logic [31:0]    mem_a;
  logic           mem_wr, io_buffer_full;

  mem_controller #(.LSB_ID_W(IDW), .IO_MASK(2'b11)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .lsb2mem_load_en(lsb2mem_load_en), .lsb2mem_store_en(lsb2mem_store_en),
    .lsb2mem_addr(lsb2mem_addr), .lsb2mem_type(lsb2mem_type), .lsb2mem_val(lsb2mem_val),
    .lsb2mem_load_id(lsb2mem_load_id), .mem_busy(mem_busy),
    .mem2lsb_load_en(mem2lsb_load_en), .mem2lsb_load_id(mem2lsb_load_id),
    .mem2lsb_load_val(mem2lsb_load_val), .if_req_en(if_req_en), .if_addr(if_addr),
    .mem2if_en(mem2if_en), .mem2if_inst(mem2if_inst), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IDW-1:0] id; logic [31:0] val; int due; } ld_exp_t;
  typedef struct { logic [31:0] inst; int due; } if_exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_exp_t;

  ld_exp_t    exp_ld[$];
  if_exp_t    exp_if[$];
  wr_exp_t    exp_wr[$];
  logic [7:0] ref_ram[int unsigned];
  logic [7:0] bus_ram[int unsigned];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         n_load_seen = 0;

  function automatic logic [7:0] init_b(input logic [31:0] a);
    return a[7:0] ^ {a[12:8], 3'b101} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_ram.exists(a)) return ref_ram[a];
    return init_b(a);
  endfunction

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    if (bus_ram.exists(a)) return bus_ram[a];
    return init_b(a);
  endfunction

  function automatic int nbytes(input logic [2:0] ty);
    if (ty[1:0] == 2'b00) return 1;
    if (ty[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Little-endian value of n bytes, then two's-complement reinterpretation for lb/lh.
  function automatic logic [31:0] model_load(input logic [2:0] ty, input logic [31:0] a);
    logic [31:0] raw;
    raw = 0;
    for (int i = 0; i < nbytes(ty); i++) raw = raw + (32'(ref_rd(a + 32'(i))) << (8 * i));
    if (ty == 3'b000 && raw >= 32'd128)   return raw - 32'd256;
    if (ty == 3'b001 && raw >= 32'd32768) return raw - 32'd65536;
    return raw;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ref_ram[a] = d;
    bus_ram[a] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lsb_issue(input bit st, input logic [2:0] ty, input logic [31:0] a,
                           input logic [31:0] v, input logic [IDW-1:0] id, input bit direct,
                           input bit expect_resp);
    wr_exp_t w;
    ld_exp_t l;
    if (st) begin
      for (int i = 0; i < nbytes(ty); i++) begin
        w.a = a + 32'(i);
        w.d = 8'(v >> (8 * i));
        exp_wr.push_back(w);
        ref_ram[w.a] = w.d;
      end
    end else if (expect_resp) begin
      l.id  = id;
      l.val = model_load(ty, a);
      l.due = direct ? cyc + nbytes(ty) + 1 : -1;
      exp_ld.push_back(l);
    end
    lsb2mem_store_en = st;
    lsb2mem_load_en  = !st;
    lsb2mem_addr     = a;
    lsb2mem_type     = ty;
    lsb2mem_val      = v;
    lsb2mem_load_id  = id;
  endtask

  task automatic lsb_clear();
    lsb2mem_store_en = 1'b0;
    lsb2mem_load_en  = 1'b0;
  endtask

  task automatic lsb_op(input bit st, input logic [2:0] ty, input logic [31:0] a,
                        input logic [31:0] v, input logic [IDW-1:0] id, input bit direct,
                        input bit expect_resp);
    lsb_issue(st, ty, a, v, id, direct, expect_resp);
    tick();
    lsb_clear();
  endtask

  task automatic fetch_issue(input logic [31:0] a);
    if_exp_t f;
    f.inst = 0;
    for (int i = 0; i < 4; i++) f.inst = f.inst + (32'(ref_rd(a + 32'(i))) << (8 * i));
    f.due     = cyc + 5;
    if_addr   = a;
    if_req_en = 1'b1;
    exp_if.push_back(f);
  endtask

  task automatic wait_quiet(input int lim);
    int k;
    k = 0;
    while ((mem_busy || if_req_en) && k < lim) begin
      tick();
      k++;
    end
    check("quiet_timeout", {31'd0, mem_busy | if_req_en}, 32'd0);
  endtask

  task automatic random_lsb(input bit direct);
    logic [2:0] ty;
    bit         st;
    st = ($urandom_range(0, 2) == 0);
    if (st) ty = 3'($urandom_range(0, 2));
    else    ty = (3'($urandom_range(0, 4)) + 3'd0);
    if (!st && ty == 3'd3) ty = 3'b100;
    if (!st && ty == 3'd4) ty = 3'b101;
    lsb_op(st, ty, 32'h100 + 32'($urandom_range(0, 63)), $urandom, IDW'($urandom_range(0, 15)),
           direct, 1'b1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Port-side RAM: one-cycle read latency, writes land on the clock edge.
  initial forever begin
    @(posedge clk);
    if (mem_wr) bus_ram[mem_a] = mem_dout;
    mem_din <= bus_rd(mem_a);
  end

  initial begin : monitor
    ld_exp_t l;
    if_exp_t f;
    wr_exp_t w;
    forever begin
      @(negedge clk);
      if (!rst_in) begin
        if (mem2lsb_load_en) begin
          n_load_seen++;
          if (exp_ld.size() == 0) begin
            check("load_unexpected", 32'd1, 32'd0);
          end else begin
            l = exp_ld.pop_front();
            check("load_val", mem2lsb_load_val, l.val);
            check("load_id", 32'(mem2lsb_load_id), 32'(l.id));
            if (l.due >= 0) check("load_latency", cyc, l.due);
          end
        end
        if (mem2if_en) begin
          if_req_en = 1'b0;
          if (exp_if.size() == 0) begin
            check("fetch_unexpected", 32'd1, 32'd0);
          end else begin
            f = exp_if.pop_front();
            check("fetch_inst", mem2if_inst, f.inst);
            check("fetch_latency", cyc, f.due);
          end
        end
        if (mem_wr) begin
          if (exp_wr.size() == 0) begin
            check("write_unexpected", mem_a, 32'd0);
          end else begin
            w = exp_wr.pop_front();
            check("write_addr", mem_a, w.a);
            check("write_data", 32'(mem_dout), 32'(w.d));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int seen0;
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    lsb2mem_load_en = 1'b0; lsb2mem_store_en = 1'b0; lsb2mem_addr = '0;
    lsb2mem_type = '0; lsb2mem_val = '0; lsb2mem_load_id = '0;
    if_req_en = 1'b0; if_addr = '0;
    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    preload(32'h10, 8'h80);
    preload(32'h20, 8'h01); preload(32'h21, 8'h80);

    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", {31'd0, mem_busy}, 32'd0);
    check("rst_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_addr", mem_a, 32'd0);
    check("rst_load_en", {31'd0, mem2lsb_load_en}, 32'd0);
    check("rst_if_en", {31'd0, mem2if_en}, 32'd0);
    tick();
    rst_in = 1'b0;
    tick();

    // lw, lb, lbu, lh with known RAM contents
    lsb_op(1'b0, 3'b010, 32'h100, 0, 4'd5, 1'b1, 1'b1); wait_quiet(20);
    lsb_op(1'b0, 3'b000, 32'h10, 0, 4'd1, 1'b1, 1'b1);  wait_quiet(20);
    lsb_op(1'b0, 3'b100, 32'h10, 0, 4'd2, 1'b1, 1'b1);  wait_quiet(20);
    lsb_op(1'b0, 3'b001, 32'h20, 0, 4'd3, 1'b1, 1'b1);  wait_quiet(20);

    // sw
    lsb_op(1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF, 4'd0, 1'b1, 1'b1); wait_quiet(20);

    // Fetch in flight, LSB load parks in the skid; busy must not drop in between
    fetch_issue(32'h0);
    tick();
    lsb_op(1'b0, 3'b010, 32'h104, 0, 4'd9, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy_fetch_skid", {31'd0, mem_busy}, 32'd1);
      tick();
    end
    wait_quiet(30);

    // IO store stalled for 3 cycles
    io_buffer_full = 1'b1;
    lsb_issue(1'b1, 3'b000, 32'h0003_0000, 32'h41, 4'd0, 1'b1, 1'b1);
    @(negedge clk); check("io_stall0", {31'd0, mem_wr}, 32'd0);
    tick(); lsb_clear();
    @(negedge clk); check("io_stall1", {31'd0, mem_wr}, 32'd0);
    tick();
    @(negedge clk); check("io_stall2", {31'd0, mem_wr}, 32'd0);
    tick(); io_buffer_full = 1'b0;
    @(negedge clk); check("io_write", {31'd0, mem_wr}, 32'd1);
    tick();
    wait_quiet(20);

    // rdy_in low freezes a store mid-way
    lsb_issue(1'b1, 3'b010, 32'h140, 32'hA1B2_C3D4, 4'd0, 1'b0, 1'b1);
    tick(); lsb_clear(); rdy_in = 1'b0;
    @(negedge clk); check("rdy_freeze0", {31'd0, mem_wr}, 32'd0);
    tick();
    @(negedge clk); check("rdy_freeze1", {31'd0, mem_wr}, 32'd0);
    tick(); rdy_in = 1'b1;
    wait_quiet(20);

    // Flush mid-lw: no response, idle the next cycle
    seen0 = n_load_seen;
    lsb_op(1'b0, 3'b010, 32'h108, 0, 4'd7, 1'b0, 1'b0);
    tick(); flush = 1'b1;
    tick(); flush = 1'b0;
    @(negedge clk); check("flush_lw_busy", {31'd0, mem_busy}, 32'd0);
    repeat (8) tick();
    check("flush_lw_no_resp", n_load_seen - seen0, 32'd0);

    // Flush mid-sw with a load in the skid: store completes, load dropped
    seen0 = n_load_seen;
    lsb_op(1'b1, 3'b010, 32'h150, 32'h1122_3344, 4'd0, 1'b0, 1'b1);
    lsb_op(1'b0, 3'b010, 32'h160, 0, 4'd6, 1'b0, 1'b0);
    flush = 1'b1;
    tick(); flush = 1'b0;
    wait_quiet(20);
    repeat (6) tick();
    check("flush_sw_writes", exp_wr.size(), 32'd0);
    check("flush_skid_dropped", n_load_seen - seen0, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        fetch_issue(32'($urandom_range(0, 63)) << 2);
        tick();
        if ($urandom_range(0, 1) == 1) random_lsb(1'b0);
        wait_quiet(60);
      end else begin
        random_lsb(1'b1);
        wait_quiet(20);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (10) tick();
    check("drain_loads", exp_ld.size(), 32'd0);
    check("drain_fetches", exp_if.size(), 32'd0);
    check("drain_writes", exp_wr.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
